// File: rtl/lockstep_checker.sv
// Lockstep checker: buffers primary-core retirements, compares them in order
// against the secondary core and keeps sticky fault status for the SoC.
module lockstep_checker #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     p_valid,
   input  logic [XLEN-1:0]          p_pc,
   input  logic [XLEN-1:0]          p_result,
   input  logic                     s_valid,
   input  logic [XLEN-1:0]          s_pc,
   input  logic [XLEN-1:0]          s_result,
   output logic                     fault,
   output logic [1:0]               fault_cause,
   output logic [XLEN-1:0]          fault_pc,
   output logic [CNT_W-1:0]         fault_count,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     checking
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_DATA = 2'b01;
   localparam logic [1:0] CAUSE_SKEW = 2'b10;
   localparam logic [1:0] CAUSE_LEAD = 2'b11;

   typedef enum logic {IDLE, CHECK} state_t;

   state_t            state, state_nxt;
   logic [2*XLEN-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              full, empty;
   logic [XLEN-1:0]   head_pc, head_res;

   logic              push, pop, flush, cmp_en;
   logic [XLEN-1:0]   cmp_pc_a, cmp_res_a;
   logic              ev;
   logic [1:0]        ev_cause;
   logic [XLEN-1:0]   ev_pc;

   // Counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign full     = (level == LVL_FULL);
   assign empty    = (level == '0);
   assign head_pc  = mem[rd_ptr][2*XLEN-1:XLEN];
   assign head_res = mem[rd_ptr][XLEN-1:0];
   assign checking = (state == CHECK);

   // Next state, FIFO control and event detection for the current cycle.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      cmp_en    = 1'b0;
      cmp_pc_a  = head_pc;
      cmp_res_a = head_res;
      ev        = 1'b0;
      ev_cause  = CAUSE_NONE;
      ev_pc     = '0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = CHECK;
         end
         CHECK: begin
            if (!enable) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else begin
               case ({p_valid, s_valid})
                  2'b10: begin
                     if (full) begin
                        ev       = 1'b1;
                        ev_cause = CAUSE_SKEW;
                        ev_pc    = p_pc;
                     end else begin
                        push = 1'b1;
                     end
                  end
                  2'b01: begin
                     if (empty) begin
                        ev       = 1'b1;
                        ev_cause = CAUSE_LEAD;
                        ev_pc    = s_pc;
                     end else begin
                        pop    = 1'b1;
                        cmp_en = 1'b1;
                     end
                  end
                  2'b11: begin
                     // Empty FIFO: compare the two cores directly, store nothing.
                     if (empty) begin
                        cmp_en    = 1'b1;
                        cmp_pc_a  = p_pc;
                        cmp_res_a = p_result;
                     end else begin
                        pop    = 1'b1;
                        push   = 1'b1;
                        cmp_en = 1'b1;
                     end
                  end
                  default: ;
               endcase
               if (cmp_en && ((cmp_pc_a != s_pc) || (cmp_res_a != s_result))) begin
                  ev       = 1'b1;
                  ev_cause = CAUSE_DATA;
                  ev_pc    = cmp_pc_a;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // FIFO storage; contents are only meaningful below the current level.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {p_pc, p_result};
   end

   // FIFO pointers and occupancy; leaving CHECK discards buffered entries.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

   // Sticky fault status; an event in the same cycle as clear takes priority.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fault       <= 1'b0;
         fault_cause <= CAUSE_NONE;
         fault_pc    <= '0;
         fault_count <= '0;
      end else if (ev) begin
         fault <= 1'b1;
         if (!fault || clear) begin
            fault_cause <= ev_cause;
            fault_pc    <= ev_pc;
         end
         fault_count <= clear ? CNT_W'(1) : sat_inc(fault_count);
      end else if (clear) begin
         fault       <= 1'b0;
         fault_cause <= CAUSE_NONE;
         fault_pc    <= '0;
         fault_count <= '0;
      end
   end

endmodule

// File: tb/tb_lockstep_checker.sv
// Testbench for lockstep_checker: a behavioural model queues the expected
// outputs for every driven cycle, which are popped and compared after the edge.
module tb_lockstep_checker;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic              clk = 1'b0;
   logic              rstn;
   logic              enable, clear;
   logic              p_valid, s_valid;
   logic [XLEN-1:0]   p_pc, p_result, s_pc, s_result;
   logic              fault;
   logic [1:0]        fault_cause;
   logic [XLEN-1:0]   fault_pc;
   logic [CNT_W-1:0]  fault_count;
   logic [$clog2(DEPTH):0] level;
   logic              checking;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        f;
      logic [1:0]  c;
      logic [31:0] pc;
      logic [7:0]  cnt;
      logic [2:0]  lvl;
      logic        chk;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] m_q[$];
   logic        m_check;
   logic        m_fault;
   logic [1:0]  m_cause;
   logic [31:0] m_pc;
   logic [7:0]  m_cnt;

   lockstep_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .clear(clear),
      .p_valid(p_valid), .p_pc(p_pc), .p_result(p_result),
      .s_valid(s_valid), .s_pc(s_pc), .s_result(s_result),
      .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc),
      .fault_count(fault_count), .level(level), .checking(checking)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_check = 1'b0;
      m_q.delete();
      m_fault = 1'b0;
      m_cause = 2'b00;
      m_pc    = '0;
      m_cnt   = '0;
   endtask

   task automatic step(input logic en, input logic clr,
                       input logic pv, input logic [31:0] ppc, input logic [31:0] pres,
                       input logic sv, input logic [31:0] spc, input logic [31:0] sres);
      exp_t        e;
      logic        ev;
      logic [1:0]  c;
      logic [31:0] epc;
      logic [63:0] head;
      @(negedge clk);
      enable = en; clear = clr;
      p_valid = pv; p_pc = ppc; p_result = pres;
      s_valid = sv; s_pc = spc; s_result = sres;
      ev = 1'b0; c = 2'b00; epc = '0;
      if (m_check && en) begin
         if (pv && !sv) begin
            if (m_q.size() == DEPTH) begin ev = 1'b1; c = 2'b10; epc = ppc; end
            else m_q.push_back({ppc, pres});
         end else if (!pv && sv) begin
            if (m_q.size() == 0) begin ev = 1'b1; c = 2'b11; epc = spc; end
            else begin
               head = m_q.pop_front();
               if (head != {spc, sres}) begin ev = 1'b1; c = 2'b01; epc = head[63:32]; end
            end
         end else if (pv && sv) begin
            if (m_q.size() == 0) head = {ppc, pres};
            else begin
               head = m_q.pop_front();
               m_q.push_back({ppc, pres});
            end
            if (head != {spc, sres}) begin ev = 1'b1; c = 2'b01; epc = head[63:32]; end
         end
      end
      if (ev) begin
         if (!m_fault || clr) begin m_cause = c; m_pc = epc; end
         m_cnt   = clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
         m_fault = 1'b1;
      end else if (clr) begin
         m_fault = 1'b0; m_cause = 2'b00; m_pc = '0; m_cnt = '0;
      end
      if (!m_check && en) m_check = 1'b1;
      else if (m_check && !en) begin m_check = 1'b0; m_q.delete(); end
      e.f = m_fault; e.c = m_cause; e.pc = m_pc; e.cnt = m_cnt;
      e.lvl = 3'(m_q.size()); e.chk = m_check;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("fault",       64'(fault),       64'(e.f));
      chk("fault_cause", 64'(fault_cause), 64'(e.c));
      chk("fault_pc",    64'(fault_pc),    64'(e.pc));
      chk("fault_count", 64'(fault_count), 64'(e.cnt));
      chk("level",       64'(level),       64'(e.lvl));
      chk("checking",    64'(checking),    64'(e.chk));
   endtask

   initial begin
      rstn = 1'b0; enable = 1'b0; clear = 1'b0;
      p_valid = 1'b0; p_pc = '0; p_result = '0;
      s_valid = 1'b0; s_pc = '0; s_result = '0;
      model_reset();
      #12;
      chk("rst_fault",    64'(fault),       64'd0);
      chk("rst_cause",    64'(fault_cause), 64'd0);
      chk("rst_pc",       64'(fault_pc),    64'd0);
      chk("rst_count",    64'(fault_count), 64'd0);
      chk("rst_level",    64'(level),       64'd0);
      chk("rst_checking", 64'(checking),    64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Valids are ignored while IDLE; enabling moves to CHECK.
      step(0, 0, 1, 32'h10, 32'h1, 0, 32'h0, 32'h0);
      step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      chk("t0_checking", 64'(checking), 64'd1);

      // Secondary trails primary by two retirements.
      step(1, 0, 1, 32'h100, 32'h11, 0, 32'h0, 32'h0);
      step(1, 0, 1, 32'h104, 32'h22, 0, 32'h0, 32'h0);
      chk("t1_peak", 64'(level), 64'd2);
      step(1, 0, 1, 32'h108, 32'h33, 1, 32'h100, 32'h11);
      step(1, 0, 0, 32'h0, 32'h0, 1, 32'h104, 32'h22);
      step(1, 0, 0, 32'h0, 32'h0, 1, 32'h108, 32'h33);
      chk("t1_fault", 64'(fault), 64'd0);
      chk("t1_count", 64'(fault_count), 64'd0);

      // Bypass result mismatch.
      step(1, 0, 1, 32'h1FC, 32'h5, 1, 32'h1FC, 32'h5);
      step(1, 0, 1, 32'h200, 32'h2A, 1, 32'h200, 32'h0);
      chk("t2_cause", 64'(fault_cause), 64'd1);
      chk("t2_pc",    64'(fault_pc),    64'h200);
      chk("t2_count", 64'(fault_count), 64'd1);
      step(1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

      // Overrun: five primaries into a depth-4 FIFO, then drain.
      for (int i = 0; i < 5; i++)
         step(1, 0, 1, 32'h600 + 32'(4*i), 32'(i), 0, 32'h0, 32'h0);
      chk("t3_level", 64'(level), 64'd4);
      chk("t3_cause", 64'(fault_cause), 64'd2);
      chk("t3_count", 64'(fault_count), 64'd1);
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, 32'h0, 32'h0, 1, 32'h600 + 32'(4*i), 32'(i));
      chk("t3_drain", 64'(level), 64'd0);
      chk("t3_count2", 64'(fault_count), 64'd1);
      step(1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

      // Secondary ahead, then a later mismatch keeps the first cause.
      step(1, 0, 0, 32'h0, 32'h0, 1, 32'h300, 32'h7);
      chk("t4_cause", 64'(fault_cause), 64'd3);
      chk("t4_pc",    64'(fault_pc),    64'h300);
      step(1, 0, 1, 32'h304, 32'h1, 1, 32'h308, 32'h1);
      chk("t4_cause2", 64'(fault_cause), 64'd3);
      chk("t4_count",  64'(fault_count), 64'd2);

      // Event coinciding with clear wins; a lone clear then zeroes status.
      step(1, 1, 1, 32'h400, 32'h9, 1, 32'h400, 32'h8);
      chk("t5_fault", 64'(fault), 64'd1);
      chk("t5_count", 64'(fault_count), 64'd1);
      chk("t5_cause", 64'(fault_cause), 64'd1);
      chk("t5_pc",    64'(fault_pc),    64'h400);
      step(1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      chk("t5_clr", 64'({fault, fault_cause, fault_count}), 64'd0);

      // Full FIFO with both valid is a pop+push, then head PC mismatch.
      for (int i = 0; i < 4; i++)
         step(1, 0, 1, 32'h700 + 32'(4*i), 32'h70 + 32'(i), 0, 32'h0, 32'h0);
      step(1, 0, 1, 32'h710, 32'h74, 1, 32'h700, 32'h70);
      chk("t6_full_level", 64'(level), 64'd4);
      chk("t6_full_fault", 64'(fault), 64'd0);
      step(1, 0, 0, 32'h0, 32'h0, 1, 32'h7FF, 32'h71);
      chk("t6_pc", 64'(fault_pc), 64'h704);
      step(1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

      // Dropping enable flushes the FIFO; re-enable and run bypass traffic.
      step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++)
         step(1, 0, 1, 32'h800 + 32'(4*i), 32'(i), 0, 32'h0, 32'h0);
      step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      chk("t7_level", 64'(level), 64'd0);
      chk("t7_checking", 64'(checking), 64'd0);
      step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      step(1, 0, 1, 32'h900, 32'h1, 1, 32'h900, 32'h1);
      step(1, 0, 1, 32'h904, 32'h2, 1, 32'h904, 32'h2);
      chk("t7_fault", 64'(fault), 64'd0);

      // Counter saturation through repeated overruns.
      for (int i = 0; i < 4; i++)
         step(1, 0, 1, 32'hA00 + 32'(4*i), 32'(i), 0, 32'h0, 32'h0);
      for (int i = 0; i < 260; i++)
         step(1, 0, 1, 32'hB00 + 32'(4*i), 32'(i), 0, 32'h0, 32'h0);
      chk("t8_sat", 64'(fault_count), 64'hFF);

      // Asynchronous reset mid-stream.
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      chk("t9_fault",    64'(fault),       64'd0);
      chk("t9_cause",    64'(fault_cause), 64'd0);
      chk("t9_pc",       64'(fault_pc),    64'd0);
      chk("t9_count",    64'(fault_count), 64'd0);
      chk("t9_level",    64'(level),       64'd0);
      chk("t9_checking", 64'(checking),    64'd0);
      @(negedge clk);
      rstn = 1'b1;
      step(0, 0, 1, 32'h1, 32'h1, 1, 32'h2, 32'h2);
      chk("t9_queue", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Sits directly downstream of the primary and redundant (secondary) CPU cores in the SoC.
- Consumes each core's retire stream (PC and ALU result) while redundant mode is active.
- Tolerates a bounded skew between the two cores by buffering primary retirements in a FIFO.
- Compares the streams in order and raises a sticky fault, with cause, count and offending PC, for the SoC fault/LED logic.

Parameters:
- XLEN, 32, width of PC and result fields.
- DEPTH, 4, primary-entry FIFO depth (maximum primary lead in retirements); power of two, at least 2.
- CNT_W, 8, width of the saturating fault counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  redundant mode active (driven from the core's is_redundant).
- clear  in  1  synchronous clear of fault status.
- p_valid  in  1  primary core retired an instruction this cycle.
- p_pc  in  XLEN  primary retired PC.
- p_result  in  XLEN  primary ALU result.
- s_valid  in  1  secondary core retired an instruction this cycle.
- s_pc  in  XLEN  secondary retired PC.
- s_result  in  XLEN  secondary ALU result.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  first cause since clear: 00 none, 01 DATA, 10 SKEW, 11 LEAD.
- fault_pc  out  XLEN  PC associated with the first fault.
- fault_count  out  CNT_W  saturating count of fault events.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- checking  out  1  state is CHECK.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, FIFO empty, and every output 0.
- FSM, two states:
  - IDLE -> CHECK on the rising clock edge where enable=1.
  - CHECK -> IDLE on the edge where enable=0; the FIFO is flushed (level=0) on that edge.
  - Fault status is preserved across IDLE/CHECK transitions.
- In IDLE: p_valid and s_valid are ignored; no push, pop or compare.
- In CHECK, each cycle resolves one case:
  - p_valid only, FIFO not full: push {p_pc,p_result}.
  - p_valid only, FIFO full: SKEW event; the entry is dropped and the FIFO is unchanged.
  - s_valid only, FIFO not empty: pop the head and compare it with {s_pc,s_result}.
  - s_valid only, FIFO empty: LEAD event (secondary ahead of primary); fault_pc = s_pc.
  - both valid, FIFO empty: bypass compare of the p_* inputs against the s_* inputs; nothing stored; level stays 0.
  - both valid, FIFO not empty: pop and compare the head with the s_* inputs, and push the p_* inputs in the same edge. This includes the FIFO-full case, which is not SKEW; level is unchanged.
- A compare mismatches if the PCs differ or the results differ. A mismatch is a DATA event with fault_pc = the primary (head or bypass) PC.
- On any event:
  - fault becomes 1 on the same edge (registered; visible the cycle after the offending inputs).
  - fault_count increments and saturates at 2^CNT_W-1.
  - fault_cause and fault_pc are written only if fault was 0 before the edge (first-fault capture).
  - At most one event per cycle.
- clear:
  - Zeroes fault, fault_cause, fault_pc and fault_count.
  - Does not touch the FIFO or the FSM.
  - If clear and an event coincide, the event wins: fault=1, count=1, and cause/pc are taken from that event.
- FIFO pointers wrap modulo DEPTH; level tracks occupancy exactly, 0..DEPTH.
- checking = 1 exactly while in CHECK.
- Reset mid-stream: immediately returns to reset values, discarding buffered entries.

Test Plan:
- enable=1; primary retires pc=0x100/0x104/0x108 over 3 cycles, secondary retires the same values 2 cycles later with matching results -> level peaks at 2; fault=0; fault_count=0.
- Lockstep match except secondary result 0x00000000 vs primary 0x0000002A at pc 0x200 -> one cycle after the compare: fault=1, fault_cause=01, fault_pc=0x200, fault_count=1.
- DEPTH=4: 5 primary retirements with no secondary -> level=4; on the 5th, fault_cause=10 and fault_count=1. Then 4 matching secondary retirements -> no further faults; level returns to 0.
- s_valid with an empty FIFO, s_pc=0x300 -> fault_cause=11, fault_pc=0x300. Then a DATA mismatch -> cause stays 11, count=2.
- clear pulsed in the same cycle as a DATA mismatch at pc 0x400 -> fault=1, count=1, cause=01, fault_pc=0x400. A clear pulse alone afterwards -> all fault outputs 0.
- Fill 3 entries, then drop enable -> level=0 and checking=0 on the next edge. Re-enable with matching bypass traffic -> no fault. Assert rstn low mid-stream -> all outputs 0 immediately.
